// File: rtl/fmc150_spi_ctrl_if.sv
// Register-bank side of the FMC150 SPI engine.
// Request fields in, read data and status out.
interface fmc150_spi_ctrl_if;
  logic        start;
  logic        rw;
  logic [3:0]  cs;
  logic [6:0]  addr;
  logic [23:0] wdata;
  logic [23:0] rdata;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output start, rw, cs, addr, wdata,
    input  rdata, busy, done, err
  );

  modport slave (
    input  start, rw, cs, addr, wdata,
    output rdata, busy, done, err
  );
endinterface

// File: rtl/fmc150_spi_ctrl.sv
// FMC150 SPI transaction engine: one register-bank request
// becomes one mode-0 SPI frame to CDCE, ADC, DAC or MON.
module fmc150_spi_ctrl #(
  parameter int g_clk_div = 8
) (
  input  logic clk_sys_i,
  input  logic rst_i,
  fmc150_spi_ctrl_if.slave bus,
  output logic spi_sclk_o,
  output logic spi_sdata_o,
  output logic cdce_n_en_o,
  output logic adc_n_en_o,
  output logic dac_n_en_o,
  output logic mon_n_en_o,
  input  logic cdce_sdo_i,
  input  logic adc_sdo_i,
  input  logic dac_sdo_i,
  input  logic mon_sdo_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_HIGH, S_LOW, S_HOLD, S_DONE
  } state_t;

  localparam logic [7:0] c_last = 8'(g_clk_div - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  bit_q, bit_d;
  logic [31:0] sreg_q, sreg_d;
  logic [23:0] shad_q, shad_d;
  logic [23:0] data_q, data_d;
  logic [3:0]  cs_q, cs_d;
  logic        rw_q, rw_d;
  logic        err_q, err_d;
  logic [1:0]  sync_q;

  logic        onehot;
  logic        tick;
  logic        active;
  logic        miso;
  logic [4:0]  last_bit;
  logic [4:0]  first_data;
  logic [31:0] frame;
  logic [3:0]  cs_m1;

  assign cs_m1  = bus.cs - 4'd1;
  assign onehot = (bus.cs != 4'd0) && ((bus.cs & cs_m1) == 4'd0);
  assign tick   = (cnt_q == c_last);
  assign active = (state_q == S_SETUP) || (state_q == S_HIGH) ||
                  (state_q == S_LOW)   || (state_q == S_HOLD);
  assign miso   = |(cs_q & {mon_sdo_i, dac_sdo_i, adc_sdo_i, cdce_sdo_i});

  // CDCE/MON frames are 32 bits, ADC/DAC 16; read data sits in the tail.
  assign last_bit   = (cs_q[0] | cs_q[3]) ? 5'd31 : 5'd15;
  assign first_data = cs_q[3] ? 5'd16 : 5'd8;

  // Left-aligned frame image built from the incoming request.
  always_comb begin
    frame = '0;
    if (bus.cs[0])
      frame = {bus.rw, bus.addr, bus.wdata};
    else if (bus.cs[3])
      frame = {bus.rw, bus.addr, 8'h00, bus.wdata[15:0]};
    else
      frame = {bus.rw, bus.addr, bus.wdata[7:0], 16'h0000};
  end

  // Next-state, phase counter, shift and capture logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    bit_d   = bit_q;
    sreg_d  = sreg_q;
    shad_d  = shad_q;
    data_d  = data_q;
    cs_d    = cs_q;
    rw_d    = rw_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.start) begin
          if (onehot) begin
            state_d = S_SETUP;
            cs_d    = bus.cs;
            rw_d    = bus.rw;
            sreg_d  = frame;
            shad_d  = '0;
            bit_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SETUP: begin
        if (tick) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end
      end
      S_HIGH: begin
        if (tick) begin
          state_d = S_LOW;
          cnt_d   = '0;
          sreg_d  = {sreg_q[30:0], 1'b0};
          if (bit_q >= first_data)
            shad_d = {shad_q[22:0], sync_q[1]};
        end
      end
      S_LOW: begin
        if (tick) begin
          cnt_d = '0;
          if (bit_q == last_bit) begin
            state_d = S_HOLD;
          end else begin
            state_d = S_HIGH;
            bit_d   = bit_q + 5'd1;
          end
        end
      end
      S_HOLD: begin
        if (tick) begin
          state_d = S_DONE;
          cnt_d   = '0;
          if (rw_q)
            data_d = shad_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sreg_q  <= '0;
      shad_q  <= '0;
      data_q  <= '0;
      cs_q    <= '0;
      rw_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sreg_q  <= sreg_d;
      shad_q  <= shad_d;
      data_q  <= data_d;
      cs_q    <= cs_d;
      rw_q    <= rw_d;
      err_q   <= err_d;
    end
  end

  // Two-flop synchronizer on the selected device MISO.
  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i)
      sync_q <= '0;
    else
      sync_q <= {sync_q[0], miso};
  end

  assign spi_sclk_o  = (state_q == S_HIGH);
  assign spi_sdata_o = active & sreg_q[31];
  assign cdce_n_en_o = ~(active & cs_q[0]);
  assign adc_n_en_o  = ~(active & cs_q[1]);
  assign dac_n_en_o  = ~(active & cs_q[2]);
  assign mon_n_en_o  = ~(active & cs_q[3]);

  assign bus.rdata = data_q;
  assign bus.busy  = (state_q != S_IDLE);
  assign bus.done  = (state_q == S_DONE);
  assign bus.err   = err_q;

endmodule

// File: tb/tb_fmc150_spi_ctrl.sv
// Directed bench for fmc150_spi_ctrl with a mode-0
// MISO device model and a negedge bus monitor.
module tb_fmc150_spi_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fmc150_spi_ctrl_if bus();

  logic sclk, sdata;
  logic cdce_n, adc_n, dac_n, mon_n;
  logic [3:0] sdo;

  fmc150_spi_ctrl #(.g_clk_div(8)) dut (
    .clk_sys_i   (clk),
    .rst_i       (rst),
    .bus         (bus),
    .spi_sclk_o  (sclk),
    .spi_sdata_o (sdata),
    .cdce_n_en_o (cdce_n),
    .adc_n_en_o  (adc_n),
    .dac_n_en_o  (dac_n),
    .mon_n_en_o  (mon_n),
    .cdce_sdo_i  (sdo[0]),
    .adc_sdo_i   (sdo[1]),
    .dac_sdo_i   (sdo[2]),
    .mon_sdo_i   (sdo[3])
  );

  int pass_n = 0;
  int chk_n  = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    chk_n++;
    if (got === exp)
      pass_n++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Device model: bit k of the response is driven after k falling SCLK edges.
  logic [31:0] resp = '0;
  int          rl   = 16;
  logic [3:0]  dev  = 4'b0001;
  int          fcnt = 0;
  logic        ps   = 1'b0;
  logic        mb;
  logic [3:0]  nen;

  assign nen = {mon_n, dac_n, adc_n, cdce_n};

  always @(posedge clk) begin
    if (&nen)
      fcnt <= 0;
    else if (ps && !sclk)
      fcnt <= fcnt + 1;
    ps <= sclk;
  end

  always_comb begin
    mb = 1'b0;
    if (fcnt < rl)
      mb = resp[rl-1-fcnt];
  end

  assign sdo = mb ? dev : ~dev;

  // Bus monitor, sampled on the falling clk edge.
  int          rises  = 0;
  int          togs   = 0;
  int          busy_n = 0;
  int          done_n = 0;
  int          err_n  = 0;
  int          nen_n [4];
  logic [31:0] mosi   = '0;
  logic [23:0] dat_d  = '0;
  logic        msc    = 1'b0;

  initial for (int i = 0; i < 4; i++) nen_n[i] = 0;

  always @(negedge clk) begin
    msc <= sclk;
    if (sclk && !msc) begin
      rises <= rises + 1;
      mosi  <= {mosi[30:0], sdata};
    end
    if (sclk != msc) togs <= togs + 1;
    if (bus.busy) busy_n <= busy_n + 1;
    if (bus.done) begin
      done_n <= done_n + 1;
      dat_d  <= bus.rdata;
    end
    if (bus.err) err_n <= err_n + 1;
    for (int i = 0; i < 4; i++)
      if (!nen[i]) nen_n[i] <= nen_n[i] + 1;
  end

  int s_rises, s_togs, s_busy, s_done, s_err;
  int s_nen [4];

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic snap();
    s_rises = rises;
    s_togs  = togs;
    s_busy  = busy_n;
    s_done  = done_n;
    s_err   = err_n;
    for (int i = 0; i < 4; i++) s_nen[i] = nen_n[i];
  endtask

  task automatic launch(logic [3:0] cs, logic rw,
                        logic [6:0] addr, logic [23:0] d);
    snap();
    bus.cs    = cs;
    bus.rw    = rw;
    bus.addr  = addr;
    bus.wdata = d;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic finish(string tag, int L, int sel,
                        logic [31:0] emosi, logic [23:0] edat);
    int k;
    int oth;
    logic [31:0] m;
    k = 0;
    while (!bus.done && k < 3000) begin
      step();
      k++;
    end
    chk({tag, "_timeout"}, 32'(k < 3000), 32'd1);
    step();
    chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    chk({tag, "_busy_cyc"}, 32'(busy_n - s_busy), 32'((2*L+2)*8+1));
    chk({tag, "_nen_cyc"}, 32'(nen_n[sel] - s_nen[sel]), 32'((2*L+2)*8));
    oth = 0;
    for (int i = 0; i < 4; i++)
      if (i != sel) oth += nen_n[i] - s_nen[i];
    chk({tag, "_nen_other"}, 32'(oth), 32'd0);
    chk({tag, "_done_n"}, 32'(done_n - s_done), 32'd1);
    chk({tag, "_rises"}, 32'(rises - s_rises), 32'(L));
    m = (L == 32) ? mosi : {16'h0000, mosi[15:0]};
    chk({tag, "_mosi"}, m, emosi);
    chk({tag, "_dat_done"}, {8'h00, dat_d}, {8'h00, edat});
    chk({tag, "_rdata"}, {8'h00, bus.rdata}, {8'h00, edat});
  endtask

  initial begin
    int k;
    bus.start = 1'b0;
    bus.rw    = 1'b0;
    bus.cs    = 4'b0000;
    bus.addr  = '0;
    bus.wdata = '0;

    step();
    step();
    chk("rst_nen", {28'h0, nen}, 32'hF);
    chk("rst_sclk", {31'h0, sclk}, 32'd0);
    chk("rst_sdata", {31'h0, sdata}, 32'd0);
    chk("rst_busy", {31'h0, bus.busy}, 32'd0);
    chk("rst_flags", {30'h0, bus.done, bus.err}, 32'd0);
    chk("rst_rdata", {8'h00, bus.rdata}, 32'd0);
    rst = 1'b0;
    step();

    // Reset in the middle of a CDCE frame.
    dev = 4'b0001; rl = 32; resp = 32'h0;
    launch(4'b0001, 1'b0, 7'h11, 24'h123456);
    k = 0;
    while (rises - s_rises < 10 && k < 3000) begin
      step();
      k++;
    end
    chk("abort_reach", 32'(rises - s_rises), 32'd10);
    rst = 1'b1;
    #1;
    chk("abort_nen", {28'h0, nen}, 32'hF);
    chk("abort_sclk", {31'h0, sclk}, 32'd0);
    chk("abort_busy", {31'h0, bus.busy}, 32'd0);
    s_done = done_n;
    step();
    step();
    rst = 1'b0;
    step();
    chk("abort_nodone", 32'(done_n - s_done), 32'd0);

    // CDCE write.
    launch(4'b0001, 1'b0, 7'h00, 24'h2C0290);
    finish("cdce_wr", 32, 0, 32'h002C0290, 24'h000000);

    // ADC read returning A5.
    dev = 4'b0010; rl = 16; resp = 32'h000000A5;
    launch(4'b0010, 1'b1, 7'h05, 24'h000000);
    finish("adc_rd", 16, 1, 32'h00008500, 24'h0000A5);

    // MON read returning BEEF.
    dev = 4'b1000; rl = 32; resp = 32'h0000BEEF;
    launch(4'b1000, 1'b1, 7'h10, 24'h000000);
    finish("mon_rd", 32, 3, 32'h90000000, 24'h00BEEF);

    // Rejected starts: two bits and no bits.
    for (int t = 0; t < 2; t++) begin
      snap();
      bus.cs    = (t == 0) ? 4'b0011 : 4'b0000;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk($sformatf("err%0d_pulse", t), {31'h0, bus.err}, 32'd1);
      chk($sformatf("err%0d_busy", t), {31'h0, bus.busy}, 32'd0);
      step();
      chk($sformatf("err%0d_clear", t), {31'h0, bus.err}, 32'd0);
      step();
      chk($sformatf("err%0d_count", t), 32'(err_n - s_err), 32'd1);
      chk($sformatf("err%0d_togs", t), 32'(togs - s_togs), 32'd0);
      chk($sformatf("err%0d_nen", t), {28'h0, nen}, 32'hF);
    end

    // DAC write with a stray start mid-frame, then back-to-back start.
    dev = 4'b0100; rl = 16; resp = 32'h0;
    launch(4'b0100, 1'b0, 7'h12, 24'h00003C);
    for (int i = 0; i < 60; i++) step();
    bus.cs    = 4'b0100;
    bus.addr  = 7'h7F;
    bus.wdata = 24'h0000FF;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("dac_stray_err", 32'(err_n - s_err), 32'd0);
    finish("dac_wr", 16, 2, 32'h0000123C, 24'h00BEEF);
    launch(4'b0100, 1'b0, 7'h01, 24'h00005A);
    chk("b2b_busy", {31'h0, bus.busy}, 32'd1);
    finish("dac_wr2", 16, 2, 32'h0000015A, 24'h00BEEF);

    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end

endmodule
